// File: rtl/layer_compositor_pkg.sv
// ============================================================================
// Module : layer_compositor_pkg
// Brief  : Shared constants, types and helpers for the layer compositor.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package layer_compositor_pkg;

  // Resolution and timing
  localparam int CNT_W    = 10;
  localparam int PX_W     = 12;
  localparam int H_ACTIVE = 640;
  localparam int V_ACTIVE = 480;

  // Layer stack defaults
  localparam int NUM_LAYERS   = 4;
  localparam int BLINK_FRAMES = 30;

  // Colours (4:4:4 RGB)
  localparam logic [11:0] BG_COLOR   = 12'hfda;
  localparam logic [11:0] BOARD_LINE = 12'h543;
  localparam logic [11:0] KEY_COLOR  = 12'hf0f;

  // Layer indices; a higher index is drawn on top
  localparam int LAYER_BOARD  = 0;
  localparam int LAYER_CHESS  = 1;
  localparam int LAYER_TIMER  = 2;
  localparam int LAYER_BANNER = 3;

  typedef logic [PX_W-1:0] px_t;

  // Counter width for a modulo-n count; never below one bit
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

`default_nettype wire

// File: rtl/layer_compositor_blink_timer.sv
// ============================================================================
// Module : layer_compositor_blink_timer
// Brief  : Counts frame ticks and toggles blink_phase every BLINK_FRAMES ticks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_compositor_blink_timer #(
  parameter int BLINK_FRAMES = 30
) (
  input  logic vga_clk,
  input  logic rst,
  input  logic tick,
  output logic blink_phase
);
  import layer_compositor_pkg::*;

  localparam int             CW   = clog2_min1(BLINK_FRAMES);
  localparam logic [CW-1:0]  LAST = CW'(BLINK_FRAMES - 1);

  logic [CW-1:0] count;

  // Advance once per frame; wrap and flip the phase after the last frame
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      count       <= '0;
      blink_phase <= 1'b0;
    end else if (tick) begin
      if (count == LAST) begin
        count       <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        count <= count + 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/layer_compositor.sv
// ============================================================================
// Module : layer_compositor
// Brief  : N-layer priority pixel compositor with per-layer enable and blink,
//          fixed two-cycle latency and aligned counters for the VGA output.
//          Optional colour-key transparency: LAYER_COMPOSITOR_COLOR_KEY_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module layer_compositor #(
  parameter int              NUM_LAYERS   = layer_compositor_pkg::NUM_LAYERS,
  parameter int              PX_W         = layer_compositor_pkg::PX_W,
  parameter int              CNT_W        = layer_compositor_pkg::CNT_W,
  parameter int              H_ACTIVE     = layer_compositor_pkg::H_ACTIVE,
  parameter int              V_ACTIVE     = layer_compositor_pkg::V_ACTIVE,
  parameter logic [PX_W-1:0] BG_COLOR     = layer_compositor_pkg::BG_COLOR,
  parameter int              BLINK_FRAMES = layer_compositor_pkg::BLINK_FRAMES,
  parameter logic [PX_W-1:0] KEY_COLOR    = layer_compositor_pkg::KEY_COLOR
) (
  input  logic                       vga_clk,
  input  logic                       rst,
  input  logic [CNT_W-1:0]           h_cnt,
  input  logic [CNT_W-1:0]           v_cnt,
  input  logic [NUM_LAYERS*PX_W-1:0] layer_px,
  input  logic [NUM_LAYERS-1:0]      layer_valid,
  input  logic [NUM_LAYERS-1:0]      layer_en,
  input  logic [NUM_LAYERS-1:0]      layer_blink,
  output logic [PX_W-1:0]            pixel,
  output logic [CNT_W-1:0]           pixel_h_cnt,
  output logic [CNT_W-1:0]           pixel_v_cnt,
  output logic                       active,
  output logic                       frame_start,
  output logic                       blink_phase
);
  import layer_compositor_pkg::*;

  // Stage-1 pipeline
  logic [NUM_LAYERS*PX_W-1:0] px1;
  logic [NUM_LAYERS-1:0]      valid1;
  logic [CNT_W-1:0]           h1;
  logic [CNT_W-1:0]           v1;
  logic                       sof1;

  // Frame-stable copies of the control inputs
  logic [NUM_LAYERS-1:0]      en_sh;
  logic [NUM_LAYERS-1:0]      blink_sh;

  logic                       sof_in;
  logic                       in_area;
  logic [NUM_LAYERS-1:0]      elig;
  logic [PX_W-1:0]            chain [0:NUM_LAYERS];

  assign sof_in  = (h_cnt == '0) && (v_cnt == '0);
  assign in_area = (int'(h1) < H_ACTIVE) && (int'(v1) < V_ACTIVE);

  // Stage 1: capture renderer outputs and counters
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      px1    <= '0;
      valid1 <= '0;
      h1     <= '0;
      v1     <= '0;
      sof1   <= 1'b0;
    end else begin
      px1    <= layer_px;
      valid1 <= layer_valid;
      h1     <= h_cnt;
      v1     <= v_cnt;
      sof1   <= sof_in;
    end
  end

  // Load enables/blink on the edge that captures (0,0) so a whole frame is consistent
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      en_sh    <= '1;
      blink_sh <= '0;
    end else if (sof_in) begin
      en_sh    <= layer_en;
      blink_sh <= layer_blink;
    end
  end

  // Phase changes on the stage-2 edge of (0,0), so (0,0) still sees the old phase
  layer_compositor_blink_timer #(
    .BLINK_FRAMES (BLINK_FRAMES)
  ) u_blink_timer (
    .vga_clk     (vga_clk),
    .rst         (rst),
    .tick        (sof1),
    .blink_phase (blink_phase)
  );

  // Priority chain: each layer overrides everything below it when eligible
  assign chain[0] = BG_COLOR;

  generate
    for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_layer
      logic [PX_W-1:0] lpx;
      logic            key_hit;

      assign lpx = px1[i*PX_W +: PX_W];
`ifdef LAYER_COMPOSITOR_COLOR_KEY_EN
      assign key_hit = (lpx == KEY_COLOR);
`else
      assign key_hit = 1'b0;
`endif
      assign elig[i]    = valid1[i] & en_sh[i] & ~(blink_sh[i] & blink_phase) & ~key_hit;
      assign chain[i+1] = elig[i] ? lpx : chain[i];
    end
  endgenerate

`ifndef LAYER_COMPOSITOR_COLOR_KEY_EN
  // Key colour has no effect in this build
  logic [PX_W-1:0] unused_key_color;
  assign unused_key_color = KEY_COLOR;
`endif

  // Stage 2: register the winning pixel, blanking and aligned counters
  always_ff @(posedge vga_clk) begin
    if (rst) begin
      pixel       <= '0;
      active      <= 1'b0;
      pixel_h_cnt <= '0;
      pixel_v_cnt <= '0;
      frame_start <= 1'b0;
    end else begin
      pixel_h_cnt <= h1;
      pixel_v_cnt <= v1;
      frame_start <= sof1;
      if (in_area) begin
        pixel  <= chain[NUM_LAYERS];
        active <= 1'b1;
      end else begin
        pixel  <= '0;
        active <= 1'b0;
      end
    end
  end

endmodule

`default_nettype wire

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
- Parametrised N-layer pixel compositor; the next generation of the two-layer chess/board priority mux in the VGA display path.
- Takes per-layer pixel and valid from the render modules (board, chess, timers, result banner, cursor), applies per-layer enable and blink, and registers a single output pixel.
- Sits between the layer renderers and the VGA RGB output pins.
- Fixed 2-cycle latency, delayed counters provided for downstream alignment.

Parameters:
- NUM_LAYERS, 4, number of input layers; the highest index is topmost.
- PX_W, 12, pixel width (4:4:4 RGB).
- CNT_W, 10, width of h_cnt/v_cnt.
- H_ACTIVE, 640, active columns; h_cnt >= H_ACTIVE is blanking.
- V_ACTIVE, 480, active rows.
- BG_COLOR, 12'hfda, pixel shown in the active area when no layer wins.
- BLINK_FRAMES, 30, frames per blink half-period; must be >= 1.
- KEY_COLOR, 12'hf0f, transparent colour (optional feature only).

Ports:
- vga_clk, input, 1, pixel clock.
- rst, input, 1, synchronous active-high reset.
- h_cnt, input, CNT_W, current column.
- v_cnt, input, CNT_W, current row.
- layer_px, input, NUM_LAYERS*PX_W, layer i occupies bits [i*PX_W +: PX_W].
- layer_valid, input, NUM_LAYERS, layer i is opaque at this pixel.
- layer_en, input, NUM_LAYERS, requested layer enables; sampled only at frame start.
- layer_blink, input, NUM_LAYERS, layer is blink-gated; sampled only at frame start.
- pixel, output, PX_W, composited pixel.
- pixel_h_cnt, output, CNT_W, h_cnt delayed to align with pixel.
- pixel_v_cnt, output, CNT_W, v_cnt delayed to align with pixel.
- active, output, 1, pixel lies in the active area.
- frame_start, output, 1, one-cycle pulse aligned with output pixel (0,0).
- blink_phase, output, 1, current blink state; 1 means blink-gated layers are hidden.

Behaviour:
- Stage 1 (registered): layer_px, layer_valid, h_cnt, v_cnt, plus sof1 = (h_cnt==0 && v_cnt==0).
- Shadow registers en_sh and blink_sh load layer_en and layer_blink on the same edge that stage 1 captures h_cnt==0 && v_cnt==0. The new values therefore govern pixel (0,0) and onward. Mid-frame changes are invisible until the next frame start.
- Stage 2 (registered), layer eligibility: layer i is eligible when all of the following hold:
  - valid1[i]
  - en_sh[i]
  - !(blink_sh[i] && blink_phase)
- Stage 2 pixel selection:
  - pixel = px1 of the highest eligible index.
  - If no layer is eligible, pixel = BG_COLOR.
  - If h1 >= H_ACTIVE or v1 >= V_ACTIVE, pixel = 0 and active = 0; otherwise active = 1.
- Latency: exactly 2 vga_clk cycles from input to pixel, active, pixel_h_cnt, pixel_v_cnt and frame_start.
- Blink counter (width clog2(BLINK_FRAMES)):
  - Increments on each sof1.
  - On sof1 when the count is BLINK_FRAMES-1: count goes to 0 and blink_phase toggles.
  - blink_phase updates on the stage-2 edge, so the new phase applies from pixel (1,0) of that frame onward. Pixel (0,0) uses the old phase.
- Reset values (any cycle, including mid-frame):
  - pixel = 0, active = 0, frame_start = 0.
  - pixel_h_cnt = 0, pixel_v_cnt = 0.
  - All pipeline registers cleared.
  - en_sh = all ones, blink_sh = all zeros.
  - Blink counter = 0, blink_phase = 0.
- Counter input out of range (e.g. h_cnt=1023): treated as blanking. No state other than the pipeline registers changes.
- If (0,0) is presented on consecutive cycles, each cycle counts as a frame start.

Optional Feature:
- Macro: LAYER_COMPOSITOR_COLOR_KEY_EN.
- Defined: layer i is additionally ineligible when its px1 equals KEY_COLOR. This lets sprite ROMs mark transparency without driving a valid mask.
- Undefined: KEY_COLOR is ignored, and a pixel equal to KEY_COLOR is shown like any other colour.

Decomposition:
- Shared package holds:
  - Resolution and timing constants: H_ACTIVE, V_ACTIVE, CNT_W, PX_W.
  - Colour constants: BG_COLOR, BOARD_LINE, KEY_COLOR.
  - Layer index constants: LAYER_BOARD=0, LAYER_CHESS=1, LAYER_TIMER=2, LAYER_BANNER=3.
- One natural sub-module: blink_timer (frame-tick counter producing blink_phase).
- The priority selection is a generate loop, not a sub-module.

Test Plan:
- Reset behaviour: hold rst 3 cycles mid-frame at (100,50) → pixel=0, active=0, blink_phase=0. After release, output tracks the inputs 2 cycles later.
- Priority: layers 0 and 2 valid (px 12'h111, 12'h333), layer 3 invalid, all enabled → pixel=12'h333 two cycles later. Drop layer 2 valid → 12'h111. No layer valid → 12'hfda.
- Blanking: h_cnt=640, v_cnt=10, all layers valid → pixel=0, active=0, pixel_h_cnt=640 two cycles later.
- Enable shadowing: clear layer_en[2] at (300,200) → layer 2 is still shown for the rest of the frame. At the next (0,0) layer 2 is hidden and frame_start=1 aligned with that pixel.
- Blink: BLINK_FRAMES=2, layer_blink[1]=1, run 6 frames.
  - blink_phase toggles at frames 2 and 4.
  - Layer 1 is hidden at (5,5) in frames 2–3 and shown in frames 0–1 and 4–5.
- Colour key (macro defined): layer 3 px=12'hf0f valid, layer 1 px=12'h0a0 valid → pixel=12'h0a0. With the macro undefined → pixel=12'hf0f.
